lsu_mem_stage: RTL and testbench

Memory-stage controller sitting directly upstream of the data memory in the riscv32i core. Accepts one load/store request at a time from execute and computes the effective address. Checks alignment and bounds, then drives the data memory's instruction/address/store-data inputs for exactly one issue window. Returns load results to writeback as a registered pulse and reports address exceptions instead of issuing faulting accesses.

---
 rtl/lsu_mem_stage_pkg.sv | 32 +++
 rtl/lsu_addr_check.sv | 46 ++++
 rtl/lsu_mem_stage.sv | 157 +++++++++++++++
 tb/tb_lsu_mem_stage.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_mem_stage_pkg.sv
// Shared definitions for the memory stage: instruction encodings, exception causes, FSM states.
package lsu_mem_stage_pkg;

  localparam logic [63:0] inst_LB  = 64'h1 << 10;
  localparam logic [63:0] inst_LH  = 64'h1 << 11;
  localparam logic [63:0] inst_LW  = 64'h1 << 12;
  localparam logic [63:0] inst_LBU = 64'h1 << 13;
  localparam logic [63:0] inst_LHU = 64'h1 << 14;
  localparam logic [63:0] inst_SB  = 64'h1 << 15;
  localparam logic [63:0] inst_SH  = 64'h1 << 16;
  localparam logic [63:0] inst_SW  = 64'h1 << 17;

  localparam logic [63:0] NOP_INST_ENC = 64'h0;

  localparam logic [3:0] CAUSE_LOAD_MISALIGN  = 4'd4;
  localparam logic [3:0] CAUSE_LOAD_FAULT     = 4'd5;
  localparam logic [3:0] CAUSE_STORE_MISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_STORE_FAULT    = 4'd7;

  typedef enum logic [0:0] {
    StIdle,
    StIssue
  } lsu_state_e;

  typedef enum logic [1:0] {
    SizeNone,
    SizeByte,
    SizeHalf,
    SizeWord
  } acc_size_e;

endpackage

// File: rtl/lsu_addr_check.sv
// Combinational effective-address adder, load/store classification and exception checks.
module lsu_addr_check
  import lsu_mem_stage_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 16384
) (
  input  logic [63:0] inst,
  input  logic [31:0] base,
  input  logic [11:0] offset,
  output logic [31:0] ea,
  output logic        is_load,
  output logic        is_store,
  output logic        misaligned,
  output logic        fault,
  output logic [3:0]  cause
);

  acc_size_e size;

  always_comb begin
    ea       = base + {{20{offset[11]}}, offset};
    is_load  = 1'b0;
    is_store = 1'b0;
    size     = SizeNone;
    case (inst)
      inst_LB, inst_LBU: begin is_load  = 1'b1; size = SizeByte; end
      inst_LH, inst_LHU: begin is_load  = 1'b1; size = SizeHalf; end
      inst_LW:           begin is_load  = 1'b1; size = SizeWord; end
      inst_SB:           begin is_store = 1'b1; size = SizeByte; end
      inst_SH:           begin is_store = 1'b1; size = SizeHalf; end
      inst_SW:           begin is_store = 1'b1; size = SizeWord; end
      default:           ;
    endcase

    misaligned = ((size == SizeHalf) && ea[0]) || ((size == SizeWord) && (ea[1:0] != 2'b00));
    fault      = (ea >= MEM_BYTES);

    // Misalignment outranks the bounds fault.
    if (is_load) begin
      cause = misaligned ? CAUSE_LOAD_MISALIGN : CAUSE_LOAD_FAULT;
    end else begin
      cause = misaligned ? CAUSE_STORE_MISALIGN : CAUSE_STORE_FAULT;
    end
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-stage controller: accepts one load/store, issues it to data memory for one window,
// returns load data as a registered pulse or reports an address exception instead.
module lsu_mem_stage
  import lsu_mem_stage_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 16384,
  parameter logic [63:0] NOP_INST  = NOP_INST_ENC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_inst,
  input  logic [31:0] req_base,
  input  logic [11:0] req_offset,
  input  logic [31:0] req_store_data,
  input  logic [4:0]  req_rd,
  output logic [63:0] mem_inst,
  output logic [31:0] mem_address,
  output logic [31:0] mem_store_data,
  input  logic [31:0] mem_load_data,
  input  logic        mem_ld_avail,
  input  logic        mem_sd_avail,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        exc_valid,
  output logic [3:0]  exc_cause,
  output logic [31:0] exc_addr,
  output logic        busy
);

  lsu_state_e  state_q, state_d;
  logic        is_load_q, is_load_d;
  logic [4:0]  rd_q, rd_d;
  logic [63:0] mem_inst_q, mem_inst_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic [31:0] mem_store_data_q, mem_store_data_d;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        exc_valid_q, exc_valid_d;
  logic [3:0]  exc_cause_q, exc_cause_d;
  logic [31:0] exc_addr_q, exc_addr_d;

  logic [31:0] ea;
  logic        is_load, is_store, misaligned, fault;
  logic [3:0]  cause;

  lsu_addr_check #(
    .MEM_BYTES (MEM_BYTES)
  ) u_addr_check (
    .inst       (req_inst),
    .base       (req_base),
    .offset     (req_offset),
    .ea         (ea),
    .is_load    (is_load),
    .is_store   (is_store),
    .misaligned (misaligned),
    .fault      (fault),
    .cause      (cause)
  );

  always_comb begin
    state_d          = state_q;
    is_load_d        = is_load_q;
    rd_d             = rd_q;
    mem_inst_d       = mem_inst_q;
    mem_address_d    = mem_address_q;
    mem_store_data_d = mem_store_data_q;
    wb_valid_d       = 1'b0;
    wb_rd_d          = wb_rd_q;
    wb_data_d        = wb_data_q;
    exc_valid_d      = 1'b0;
    exc_cause_d      = exc_cause_q;
    exc_addr_d       = exc_addr_q;

    unique case (state_q)
      StIdle: begin
        // Non-memory instructions are consumed here with no side effects.
        if (req_valid && (is_load || is_store)) begin
          if (misaligned || fault) begin
            exc_valid_d = 1'b1;
            exc_cause_d = cause;
            exc_addr_d  = ea;
          end else begin
            state_d          = StIssue;
            is_load_d        = is_load;
            rd_d             = req_rd;
            mem_inst_d       = req_inst;
            mem_address_d    = ea;
            mem_store_data_d = req_store_data;
          end
        end
      end
      StIssue: begin
        if (is_load_q && mem_ld_avail) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_data_d  = mem_load_data;
          state_d    = StIdle;
          mem_inst_d = NOP_INST;
        end else if (!is_load_q && mem_sd_avail) begin
          state_d    = StIdle;
          mem_inst_d = NOP_INST;
        end
      end
      default: begin
        state_d    = StIdle;
        mem_inst_d = NOP_INST;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= StIdle;
      is_load_q        <= 1'b0;
      rd_q             <= 5'd0;
      mem_inst_q       <= NOP_INST;
      mem_address_q    <= 32'd0;
      mem_store_data_q <= 32'd0;
      wb_valid_q       <= 1'b0;
      wb_rd_q          <= 5'd0;
      wb_data_q        <= 32'd0;
      exc_valid_q      <= 1'b0;
      exc_cause_q      <= 4'd0;
      exc_addr_q       <= 32'd0;
    end else begin
      state_q          <= state_d;
      is_load_q        <= is_load_d;
      rd_q             <= rd_d;
      mem_inst_q       <= mem_inst_d;
      mem_address_q    <= mem_address_d;
      mem_store_data_q <= mem_store_data_d;
      wb_valid_q       <= wb_valid_d;
      wb_rd_q          <= wb_rd_d;
      wb_data_q        <= wb_data_d;
      exc_valid_q      <= exc_valid_d;
      exc_cause_q      <= exc_cause_d;
      exc_addr_q       <= exc_addr_d;
    end
  end

  assign req_ready      = (state_q == StIdle);
  assign busy           = (state_q != StIdle);
  assign mem_inst       = mem_inst_q;
  assign mem_address    = mem_address_q;
  assign mem_store_data = mem_store_data_q;
  assign wb_valid       = wb_valid_q;
  assign wb_rd          = wb_rd_q;
  assign wb_data        = wb_data_q;
  assign exc_valid      = exc_valid_q;
  assign exc_cause      = exc_cause_q;
  assign exc_addr       = exc_addr_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: directed scenarios plus random traffic against a transaction model.
module tb_lsu_mem_stage;
  import lsu_mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_inst;
  logic [31:0] req_base;
  logic [11:0] req_offset;
  logic [31:0] req_store_data;
  logic [4:0]  req_rd;
  logic [63:0] mem_inst;
  logic [31:0] mem_address;
  logic [31:0] mem_store_data;
  logic [31:0] mem_load_data;
  logic        mem_ld_avail;
  logic        mem_sd_avail;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        exc_valid;
  logic [3:0]  exc_cause;
  logic [31:0] exc_addr;
  logic        busy;

  lsu_mem_stage #(
    .MEM_BYTES (16384),
    .NOP_INST  (64'h0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_inst       (req_inst),
    .req_base       (req_base),
    .req_offset     (req_offset),
    .req_store_data (req_store_data),
    .req_rd         (req_rd),
    .mem_inst       (mem_inst),
    .mem_address    (mem_address),
    .mem_store_data (mem_store_data),
    .mem_load_data  (mem_load_data),
    .mem_ld_avail   (mem_ld_avail),
    .mem_sd_avail   (mem_sd_avail),
    .wb_valid       (wb_valid),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .exc_valid      (exc_valid),
    .exc_cause      (exc_cause),
    .exc_addr       (exc_addr),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- data memory environment ----------------
  logic [31:0] mem_arr [0:4095];
  int          n_writes = 0;

  function automatic logic [31:0] mem_read(input logic [63:0] inst, input logic [31:0] addr);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    w = mem_arr[addr[13:2]];
    b = w[8*addr[1:0] +: 8];
    h = w[16*addr[1] +: 16];
    case (inst)
      inst_LB:  return {{24{b[7]}}, b};
      inst_LBU: return {24'd0, b};
      inst_LH:  return {{16{h[15]}}, h};
      inst_LHU: return {16'd0, h};
      inst_LW:  return w;
      default:  return 32'd0;
    endcase
  endfunction

  assign mem_load_data = mem_read(mem_inst, mem_address);

  // ---------------- transaction-level reference model ----------------
  function automatic int unsigned acc_bytes(input logic [63:0] inst);
    if (inst == inst_LB || inst == inst_LBU || inst == inst_SB) return 1;
    if (inst == inst_LH || inst == inst_LHU || inst == inst_SH) return 2;
    if (inst == inst_LW || inst == inst_SW) return 4;
    return 0;
  endfunction

  function automatic bit is_ld(input logic [63:0] inst);
    return inst == inst_LB || inst == inst_LBU || inst == inst_LH || inst == inst_LHU ||
           inst == inst_LW;
  endfunction

  bit          m_busy = 0;
  logic [63:0] t_inst;
  logic [31:0] t_addr, t_data;
  logic [4:0]  t_rd;
  bit          e_wb_valid = 0, e_exc_valid = 0;
  logic [4:0]  e_wb_rd;
  logic [31:0] e_wb_data, e_exc_addr;
  logic [3:0]  e_exc_cause;
  int          exp_writes = 0;

  task automatic model_step();
    logic [31:0] ea;
    int unsigned sz;
    e_wb_valid  = 0;
    e_exc_valid = 0;
    if (reset) begin
      m_busy = 0;
    end else if (!m_busy) begin
      if (req_valid) begin
        ea = req_base + 32'($signed(req_offset));
        sz = acc_bytes(req_inst);
        if (sz != 0) begin
          if (ea % sz != 0) begin
            e_exc_valid = 1;
            e_exc_cause = is_ld(req_inst) ? 4'd4 : 4'd6;
            e_exc_addr  = ea;
          end else if (ea >= 32'd16384) begin
            e_exc_valid = 1;
            e_exc_cause = is_ld(req_inst) ? 4'd5 : 4'd7;
            e_exc_addr  = ea;
          end else begin
            m_busy = 1;
            t_inst = req_inst;
            t_addr = ea;
            t_data = req_store_data;
            t_rd   = req_rd;
          end
        end
      end
    end else if (is_ld(t_inst)) begin
      if (mem_ld_avail) begin
        e_wb_valid = 1;
        e_wb_data  = mem_read(t_inst, t_addr);
        e_wb_rd    = t_rd;
        m_busy     = 0;
      end
    end else if (mem_sd_avail) begin
      m_busy = 0;
      exp_writes++;
    end
  endtask

  task automatic mem_write_step();
    logic [31:0] w;
    if (!reset && mem_sd_avail &&
        (mem_inst == inst_SB || mem_inst == inst_SH || mem_inst == inst_SW)) begin
      w = mem_arr[mem_address[13:2]];
      if (mem_inst == inst_SB) w[8*mem_address[1:0] +: 8] = mem_store_data[7:0];
      else if (mem_inst == inst_SH) w[16*mem_address[1] +: 16] = mem_store_data[15:0];
      else w = mem_store_data;
      mem_arr[mem_address[13:2]] = w;
      n_writes++;
    end
  endtask

  always @(posedge clk) begin
    model_step();
    mem_write_step();
    #1;
    check("req_ready", 64'(req_ready), 64'(!m_busy));
    check("busy", 64'(busy), 64'(m_busy));
    check("mem_inst", mem_inst, m_busy ? t_inst : 64'h0);
    if (m_busy) begin
      check("mem_address", 64'(mem_address), 64'(t_addr));
      check("mem_store_data", 64'(mem_store_data), 64'(t_data));
    end
    check("wb_valid", 64'(wb_valid), 64'(e_wb_valid));
    if (e_wb_valid) begin
      check("wb_rd", 64'(wb_rd), 64'(e_wb_rd));
      check("wb_data", 64'(wb_data), 64'(e_wb_data));
    end
    check("exc_valid", 64'(exc_valid), 64'(e_exc_valid));
    if (e_exc_valid) begin
      check("exc_cause", 64'(exc_cause), 64'(e_exc_cause));
      check("exc_addr", 64'(exc_addr), 64'(e_exc_addr));
    end
  end

  // ---------------- stimulus ----------------
  task automatic offer(input logic [63:0] inst, input logic [31:0] base, input logic [11:0] off,
                       input logic [31:0] data, input logic [4:0] rd);
    req_valid      = 1'b1;
    req_inst       = inst;
    req_base       = base;
    req_offset     = off;
    req_store_data = data;
    req_rd         = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [63:0] inst_tbl [0:8];
  int          w0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    inst_tbl = '{inst_LB, inst_LH, inst_LW, inst_LBU, inst_LHU, inst_SB, inst_SH, inst_SW, 64'h3};
    for (int i = 0; i < 4096; i++) mem_arr[i] = $urandom;
    mem_arr[32'h104 >> 2] = 32'hDEADBEEF;
    mem_arr[32'h200 >> 2] = 32'h0;
    mem_arr[32'h300 >> 2] = 32'h0;
    reset = 1'b1; req_valid = 1'b0; req_inst = 64'h0; req_base = 32'd0; req_offset = 12'd0;
    req_store_data = 32'd0; req_rd = 5'd0; mem_ld_avail = 1'b1; mem_sd_avail = 1'b1;
    tick(); tick();
    check("rst req_ready", 64'(req_ready), 64'd1);
    check("rst mem_inst", mem_inst, 64'h0);
    check("rst mem_address", 64'(mem_address), 64'd0);
    check("rst wb_data", 64'(wb_data), 64'd0);
    check("rst exc_cause", 64'(exc_cause), 64'd0);

    // LW 0x100+4
    @(negedge clk); reset = 1'b0; offer(inst_LW, 32'h100, 12'd4, 32'h0, 5'd7);
    tick();
    check("lw mem_address", 64'(mem_address), 64'h104);
    check("lw mem_inst", mem_inst, inst_LW);
    @(negedge clk); req_valid = 1'b0;
    tick();
    check("lw wb_valid", 64'(wb_valid), 64'd1);
    check("lw wb_data", 64'(wb_data), 64'hDEADBEEF);
    check("lw wb_rd", 64'(wb_rd), 64'd7);

    // SH then LHU / LH at 0x202
    @(negedge clk); offer(inst_SH, 32'h202, 12'd0, 32'h1234ABCD, 5'd0);
    tick(); @(negedge clk); req_valid = 1'b0; tick();
    check("sh word", 64'(mem_arr[32'h200 >> 2]), 64'hABCD0000);
    @(negedge clk); offer(inst_LHU, 32'h202, 12'd0, 32'h0, 5'd3);
    tick(); @(negedge clk); req_valid = 1'b0; tick();
    check("lhu wb_data", 64'(wb_data), 64'h0000ABCD);
    @(negedge clk); offer(inst_LH, 32'h200, 12'd2, 32'h0, 5'd4);
    tick(); @(negedge clk); req_valid = 1'b0; tick();
    check("lh wb_data", 64'(wb_data), 64'hFFFFABCD);

    // Back-to-back exceptions
    @(negedge clk); offer(inst_LW, 32'h100, 12'd3, 32'h0, 5'd1);
    tick();
    check("misalign exc_valid", 64'(exc_valid), 64'd1);
    check("misalign cause", 64'(exc_cause), 64'd4);
    check("misalign addr", 64'(exc_addr), 64'h103);
    check("misalign mem_inst", mem_inst, 64'h0);
    check("misalign ready", 64'(req_ready), 64'd1);
    @(negedge clk); offer(inst_SW, 32'h4000, 12'd0, 32'h0, 5'd1);
    tick();
    check("sw fault cause", 64'(exc_cause), 64'd7);
    check("sw fault addr", 64'(exc_addr), 64'h4000);
    @(negedge clk); offer(inst_LW, 32'h10, 12'hFE0, 32'h0, 5'd1);
    tick();
    check("wrap cause", 64'(exc_cause), 64'd5);
    check("wrap addr", 64'(exc_addr), 64'hFFFFFFF0);
    @(negedge clk); req_valid = 1'b0;
    tick();
    check("exc cleared", 64'(exc_valid), 64'd0);

    // SW held off by store port for three cycles
    @(negedge clk); mem_sd_avail = 1'b0; w0 = n_writes;
    offer(inst_SW, 32'h180, 12'd0, 32'hCAFEF00D, 5'd0);
    tick();
    check("stall busy0", 64'(busy), 64'd1);
    @(negedge clk); req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall busy", 64'(busy), 64'd1);
      check("stall ready", 64'(req_ready), 64'd0);
      check("stall no write", 64'(n_writes - w0), 64'd0);
    end
    @(negedge clk); mem_sd_avail = 1'b1;
    tick();
    check("stall done", 64'(busy), 64'd0);
    check("stall one write", 64'(n_writes - w0), 64'd1);
    check("stall data", 64'(mem_arr[32'h180 >> 2]), 64'hCAFEF00D);

    // Reset while an SB is in ISSUE
    @(negedge clk); mem_sd_avail = 1'b0; offer(inst_SB, 32'h300, 12'd1, 32'h000000FF, 5'd0);
    tick();
    check("sb issue", mem_inst, inst_SB);
    @(negedge clk); req_valid = 1'b0; reset = 1'b1; mem_sd_avail = 1'b1;
    tick();
    check("rst busy", 64'(busy), 64'd0);
    check("rst mem_inst mid", mem_inst, 64'h0);
    check("rst sb dropped", 64'(mem_arr[32'h300 >> 2]), 64'd0);
    @(negedge clk); reset = 1'b0;
    tick();
    check("rst no wb", 64'(wb_valid), 64'd0);
    check("rst no exc", 64'(exc_valid), 64'd0);
    @(negedge clk); offer(inst_LBU, 32'h104, 12'd0, 32'h0, 5'd9);
    tick();
    check("fresh accept", 64'(busy), 64'd1);
    @(negedge clk); req_valid = 1'b0;
    tick();
    check("fresh lbu", 64'(wb_data), 64'h000000EF);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      reset        = ($urandom_range(0, 299) == 0);
      mem_ld_avail = ($urandom_range(0, 3) != 0);
      mem_sd_avail = ($urandom_range(0, 3) != 0);
      req_valid    = ($urandom_range(0, 3) != 0);
      req_inst     = inst_tbl[$urandom_range(0, 8)];
      req_base     = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 16400);
      req_offset   = 12'($urandom);
      req_store_data = $urandom;
      req_rd       = 5'($urandom);
    end
    @(negedge clk); req_valid = 1'b0; reset = 1'b0; mem_ld_avail = 1'b1; mem_sd_avail = 1'b1;
    tick(); tick(); tick();
    check("write count", 64'(n_writes), 64'(exp_writes));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
